// File: rtl/niosii_system_onchip_memory_arbiter.sv
// rtl/niosii_system_onchip_memory_arbiter.sv - round-robin two-master arbiter for the single-port on-chip memory
// Optional out-of-range guard compiled in with `define ONCHIP_ARB_RANGE_CHECK_EN
module niosii_system_onchip_memory_arbiter #(
   parameter int DEPTH  = 6500,
   parameter int ADDR_W = 13
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [3:0]        m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [31:0]       m0_writedata,
   output logic              m0_waitrequest,
   output logic [31:0]       m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [3:0]        m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [31:0]       m1_writedata,
   output logic              m1_waitrequest,
   output logic [31:0]       m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic [3:0]        mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   output logic              mem_clken,
   input  logic [31:0]       mem_readdata,
   output logic              range_err
);

   logic              w_req0;
   logic              w_req1;
   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_any_gnt;
   logic [ADDR_W-1:0] w_addr;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic              w_wr;
   logic              w_rd_acc0;
   logic              w_rd_acc1;
   logic              w_addr_oor;
   logic              w_block;
   logic [1:0]        w_zero_q;
   logic              r_last;
   logic [1:0]        r_rdv_q;

   // Requests are masked while reset is high so nothing is granted then
   assign w_req0 = ~reset & (m0_read | m0_write);
   assign w_req1 = ~reset & (m1_read | m1_write);

   // Round robin: a lone requester wins; on contention the master other than r_last wins
   assign w_gnt0    = w_req0 & (~w_req1 | r_last);
   assign w_gnt1    = w_req1 & (~w_req0 | ~r_last);
   assign w_any_gnt = w_gnt0 | w_gnt1;

   // Loser (or any requester during reset) is stalled; idle masters never see waitrequest
   assign m0_waitrequest = (m0_read | m0_write) & ~w_gnt0;
   assign m1_waitrequest = (m1_read | m1_write) & ~w_gnt1;

   // Memory-side mux defaults to m0 when nobody is granted
   assign w_addr  = w_gnt1 ? m1_address    : m0_address;
   assign w_be    = w_gnt1 ? m1_byteenable : m0_byteenable;
   assign w_wdata = w_gnt1 ? m1_writedata  : m0_writedata;
   assign w_wr    = w_gnt1 ? m1_write      : m0_write;

   // A request with both read and write set is treated as a write only
   assign w_rd_acc0 = w_gnt0 & m0_read & ~m0_write;
   assign w_rd_acc1 = w_gnt1 & m1_read & ~m1_write;

   assign w_addr_oor = (32'(w_addr) >= DEPTH);

`ifdef ONCHIP_ARB_RANGE_CHECK_EN
   logic [1:0] r_zero_q;
   logic       r_range_err;

   // Out-of-range accesses are accepted but kept away from the memory
   assign w_block = w_any_gnt & w_addr_oor;

   // Remember which pending reads must return zero, and latch the sticky error
   always_ff @(posedge clk) begin
      if (reset) begin
         r_zero_q    <= 2'b00;
         r_range_err <= 1'b0;
      end else begin
         r_zero_q <= {w_rd_acc1 & w_block, w_rd_acc0 & w_block};
         if (w_block) begin
            r_range_err <= 1'b1;
         end
      end
   end

   assign w_zero_q  = r_zero_q;
   assign range_err = r_range_err;
`else
   logic w_unused_oor;

   assign w_block      = 1'b0;
   assign w_zero_q     = 2'b00;
   assign w_unused_oor = w_addr_oor;
   assign range_err    = 1'b0;
`endif

   assign mem_chipselect = w_any_gnt & ~w_block;
   assign mem_write      = mem_chipselect & w_wr;
   assign mem_address    = w_addr;
   assign mem_byteenable = w_be;
   assign mem_writedata  = w_wdata;
   assign mem_clken      = 1'b1;

   // Track the round-robin winner and the one-cycle read-return pipeline
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last  <= 1'b1;
         r_rdv_q <= 2'b00;
      end else begin
         r_rdv_q <= {w_rd_acc1, w_rd_acc0};
         if (w_gnt0) begin
            r_last <= 1'b0;
         end else if (w_gnt1) begin
            r_last <= 1'b1;
         end
      end
   end

   // A read accepted just before reset is dropped rather than returned during reset
   assign m0_readdatavalid = r_rdv_q[0] & ~reset;
   assign m1_readdatavalid = r_rdv_q[1] & ~reset;
   assign m0_readdata      = (m0_readdatavalid & ~w_zero_q[0]) ? mem_readdata : 32'h0;
   assign m1_readdata      = (m1_readdatavalid & ~w_zero_q[1]) ? mem_readdata : 32'h0;

endmodule

// File: tb/tb_niosii_system_onchip_memory_arbiter.sv
// tb/tb_niosii_system_onchip_memory_arbiter.sv - scoreboard bench for the on-chip memory arbiter
// Range-check expectations follow `define ONCHIP_ARB_RANGE_CHECK_EN
module tb_niosii_system_onchip_memory_arbiter;

   localparam int DEPTH  = 6500;
   localparam int ADDR_W = 13;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] m0_address, m1_address;
   logic [3:0]        m0_byteenable, m1_byteenable;
   logic              m0_read, m0_write, m1_read, m1_write;
   logic [31:0]       m0_writedata, m1_writedata;
   logic              m0_waitrequest, m1_waitrequest;
   logic [31:0]       m0_readdata, m1_readdata;
   logic              m0_readdatavalid, m1_readdatavalid;
   logic [ADDR_W-1:0] mem_address;
   logic [3:0]        mem_byteenable;
   logic              mem_chipselect, mem_write, mem_clken;
   logic [31:0]       mem_writedata;
   logic [31:0]       mem_readdata;
   logic              range_err;

   niosii_system_onchip_memory_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_readdata(mem_readdata), .range_err(range_err)
   );

   always #5 clk = ~clk;

   // single-port memory with one-cycle read latency
   logic [31:0] env_mem [0:8191];
   always @(posedge clk) begin
      if (mem_chipselect && mem_write) begin
         for (int b = 0; b < 4; b++)
            if (mem_byteenable[b]) env_mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end
      mem_readdata <= env_mem[mem_address];
   end

   typedef struct { logic [31:0] d; int c; } exp_t;
   exp_t q0[$];
   exp_t q1[$];

   logic [31:0] ref_mem [0:8191];
   int   m_last;
   bit   m_rerr;
   bit   acc0, acc1;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
      end
   endfunction

   // reference: round-robin winner, memory contents and expected read returns
   task automatic check_cycle();
      logic rq0, rq1, rd, wr, oor;
      logic [ADDR_W-1:0] a;
      logic [3:0] be;
      logic [31:0] wd;
      int w;
      exp_t e;
      rq0 = m0_read | m0_write;
      rq1 = m1_read | m1_write;
      acc0 = 0; acc1 = 0;
      if (reset) begin
         chk("wait0_rst", 32'(m0_waitrequest), 32'(rq0));
         chk("wait1_rst", 32'(m1_waitrequest), 32'(rq1));
         chk("cs_rst", 32'(mem_chipselect), 0);
      end else begin
         if (rq0 && rq1) w = (m_last == 0) ? 1 : 0;
         else if (rq0) w = 0;
         else if (rq1) w = 1;
         else w = -1;
         chk("wait0", 32'(m0_waitrequest), 32'(rq0 && w != 0));
         chk("wait1", 32'(m1_waitrequest), 32'(rq1 && w != 1));
         if (w >= 0) begin
            if (w == 0) begin a = m0_address; be = m0_byteenable; wd = m0_writedata; rd = m0_read; wr = m0_write; end
            else        begin a = m1_address; be = m1_byteenable; wd = m1_writedata; rd = m1_read; wr = m1_write; end
`ifdef ONCHIP_ARB_RANGE_CHECK_EN
            oor = (int'(a) >= DEPTH);
`else
            oor = 1'b0;
`endif
            chk("cs", 32'(mem_chipselect), 32'(!oor));
            chk("mem_write", 32'(mem_write), 32'(wr && !oor));
            chk("mem_addr", 32'(mem_address), 32'(a));
            if (wr && !oor) begin
               for (int b = 0; b < 4; b++)
                  if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
            end
            if (rd && !wr) begin
               e.d = oor ? 32'h0 : ref_mem[a];
               e.c = cyc;
               if (w == 0) q0.push_back(e); else q1.push_back(e);
            end
            if (oor) m_rerr = 1;
            m_last = w;
            if (w == 0) acc0 = 1; else acc1 = 1;
         end else begin
            chk("cs_idle", 32'(mem_chipselect), 0);
            chk("mem_write_idle", 32'(mem_write), 0);
         end
      end
      chk("range_err", 32'(range_err), 32'(m_rerr));
      chk("clken", 32'(mem_clken), 1);
   endtask

   // monitor: pops the scoreboard whenever a master sees readdatavalid
   always @(negedge clk) begin
      if (m0_readdatavalid) begin
         if (q0.size() == 0 || q0[0].c != cyc - 1) chk("rdv0_unexpected", 1, 0);
         else begin chk("rdata0", m0_readdata, q0[0].d); void'(q0.pop_front()); end
      end else begin
         if (q0.size() != 0 && q0[0].c == cyc - 1) begin chk("rdv0_missing", 0, 1); void'(q0.pop_front()); end
         chk("rdata0_idle", m0_readdata, 0);
      end
      if (m1_readdatavalid) begin
         if (q1.size() == 0 || q1[0].c != cyc - 1) chk("rdv1_unexpected", 1, 0);
         else begin chk("rdata1", m1_readdata, q1[0].d); void'(q1.pop_front()); end
      end else begin
         if (q1.size() != 0 && q1[0].c == cyc - 1) begin chk("rdv1_missing", 0, 1); void'(q1.pop_front()); end
         chk("rdata1_idle", m1_readdata, 0);
      end
   end

   task automatic step();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(input int m, input logic rd, input logic wr, input int addr,
                        input logic [3:0] be, input logic [31:0] d);
      if (m == 0) begin m0_read = rd; m0_write = wr; m0_address = ADDR_W'(addr); m0_byteenable = be; m0_writedata = d; end
      else        begin m1_read = rd; m1_write = wr; m1_address = ADDR_W'(addr); m1_byteenable = be; m1_writedata = d; end
   endtask

   task automatic idle_both();
      set_m(0, 0, 0, 0, 4'h0, 0);
      set_m(1, 0, 0, 0, 4'h0, 0);
   endtask

   task automatic set_reset(input logic v);
      reset = v;
      if (v) begin
         q0.delete(); q1.delete();
         m_last = 1; m_rerr = 0;
      end
   endtask

   task automatic rand_req(input int m);
      int r;
      r = $urandom_range(0, 99);
      set_m(m, (r >= 25 && r < 60) || r >= 90, r >= 60, $urandom_range(0, 15),
            4'($urandom), $urandom);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 8192; i++) begin env_mem[i] = 0; ref_mem[i] = 0; end
      idle_both();
      set_reset(1);
      #1;
      step(); step();
      set_reset(0);
      step();

      // m0 write then read of address 5
      set_m(0, 0, 1, 5, 4'hF, 32'h11223344); step();
      set_m(0, 1, 0, 5, 4'hF, 0);            step();
      idle_both();                           step();

      // both masters reading continuously after a reset
      set_reset(1); step(); set_reset(0);
      set_m(0, 1, 0, 1, 4'hF, 0);
      set_m(1, 1, 0, 2, 4'hF, 0);
      for (int i = 0; i < 6; i++) step();
      idle_both(); step();

      // partial byte-lane write from m1
      set_m(1, 0, 1, 7, 4'hF, 32'hFFFFFFFF);   step();
      set_m(1, 0, 1, 7, 4'b0011, 32'hAABBCCDD); step();
      set_m(1, 1, 0, 7, 4'hF, 0);              step();
      idle_both(); step();

      // read and write together behave as a write
      set_m(0, 1, 1, 9, 4'hF, 32'h5); step();
      idle_both();                    step();
      set_m(0, 1, 0, 9, 4'hF, 0);     step();
      idle_both();                    step();

      // reset right after an accepted read
      set_m(0, 1, 0, 3, 4'hF, 0); step();
      set_reset(1);
      set_m(1, 1, 0, 4, 4'hF, 0); step(); step();
      set_reset(0);               step();
      set_m(1, 1, 0, 4, 4'hF, 0); step();
      idle_both(); step();

      // address at DEPTH
      set_m(1, 1, 0, DEPTH, 4'hF, 0); step();
      idle_both();                    step(); step();
      set_reset(1); step(); set_reset(0); step();

      // randomized traffic with Avalon hold-while-waiting
      acc0 = 0; acc1 = 0;
      for (int c = 0; c < 400; c++) begin
         if (acc0 || !(m0_read || m0_write)) rand_req(0);
         if (acc1 || !(m1_read || m1_write)) rand_req(1);
         step();
      end
      idle_both(); step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
